hyp_arbiter: RTL and testbench

HYP_ARBITER -- requirements
Module: hyp_arbiter

---
 rtl/hyp_arbiter.sv | 141 ++++++++++++++
 tb/tb_hyp_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hyp_arbiter.sv
// Two-port round-robin arbiter in front of a single-request HyperRAM controller.
// Latency: grant to ready is 3 + cycles spent in WAIT, so at least 4 cycles.
// Backpressure: a port is held off until IDLE sees hyp_busy low. A stuck controller ends in a timeout abort.
// Ports: m0_*/m1_* carry valid/addr/wdata/wstrb in and ready/rdata/err out.
//        hyp_* carry the single-cycle rd/wr request, latched addr/data/byte enables, and rd data/strobe/busy back.
module hyp_arbiter #(
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        m0_valid,
   input  logic [29:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_valid,
   input  logic [29:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        hyp_rd_req,
   output logic        hyp_wr_req,
   output logic [31:0] hyp_addr,
   output logic [31:0] hyp_wr_d,
   output logic [3:0]  hyp_wr_byte_en,
   input  logic [31:0] hyp_rd_d,
   input  logic        hyp_rd_rdy,
   input  logic        hyp_busy
);

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_GUARD, ST_WAIT, ST_DONE} state_t;

   // The counter is 16 bits wide, so larger TIMEOUT values clamp to the saturation point.
   localparam logic [15:0] TMO = (TIMEOUT > 32'd65535) ? 16'hFFFF : 16'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic        grant;
   logic        pick;
   logic        gnt_q;
   logic        last_grant;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [15:0] cnt;
   logic        timed_out;
   logic        is_read;
   logic        done0;
   logic        done1;

   assign timed_out = (cnt >= TMO);
   assign is_read   = (wstrb_q == 4'd0);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      pick      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!hyp_busy && (m0_valid || m1_valid)) begin
               grant     = 1'b1;
               // When both ports are valid, the port that did not win last time is granted.
               pick      = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ:   state_nxt = ST_GUARD;
         // The controller may not have raised busy yet, so GUARD ignores it for one cycle.
         ST_GUARD: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!hyp_busy || timed_out) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         gnt_q      <= 1'b0;
         last_grant <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cnt        <= '0;
      end else begin
         if (grant) begin
            gnt_q      <= pick;
            last_grant <= pick;
            addr_q     <= pick ? m1_addr  : m0_addr;
            wdata_q    <= pick ? m1_wdata : m0_wdata;
            wstrb_q    <= pick ? m1_wstrb : m0_wstrb;
         end
         case (state)
            ST_REQ: begin
               cnt     <= '0;
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            ST_GUARD, ST_WAIT: begin
               if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
               // A later strobe overwrites an earlier one.
               if (hyp_rd_rdy) rdata_q <= hyp_rd_d;
               // A busy low in the same cycle wins over the timeout.
               if (state == ST_WAIT && hyp_busy && timed_out) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Every output decodes from registered state, so reset clears them at once.
   assign hyp_rd_req     = (state == ST_REQ) && is_read;
   assign hyp_wr_req     = (state == ST_REQ) && !is_read;
   assign hyp_addr       = {2'b00, addr_q};
   assign hyp_wr_d       = wdata_q;
   assign hyp_wr_byte_en = wstrb_q;

   assign done0    = (state == ST_DONE) && !gnt_q;
   assign done1    = (state == ST_DONE) && gnt_q;
   assign m0_ready = done0;
   assign m1_ready = done1;
   assign m0_rdata = (done0 && is_read) ? rdata_q : 32'd0;
   assign m1_rdata = (done1 && is_read) ? rdata_q : 32'd0;
   assign m0_err   = done0 && err_q;
   assign m1_err   = done1 && err_q;

endmodule

// File: tb/tb_hyp_arbiter.sv
module tb_hyp_arbiter;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        m0_valid = 1'b0;
   logic [29:0] m0_addr = '0;
   logic [31:0] m0_wdata = '0;
   logic [3:0]  m0_wstrb = '0;
   logic        m0_ready;
   logic [31:0] m0_rdata;
   logic        m0_err;
   logic        m1_valid = 1'b0;
   logic [29:0] m1_addr = '0;
   logic [31:0] m1_wdata = '0;
   logic [3:0]  m1_wstrb = '0;
   logic        m1_ready;
   logic [31:0] m1_rdata;
   logic        m1_err;
   logic        hyp_rd_req;
   logic        hyp_wr_req;
   logic [31:0] hyp_addr;
   logic [31:0] hyp_wr_d;
   logic [3:0]  hyp_wr_byte_en;
   logic [31:0] hyp_rd_d = '0;
   logic        hyp_rd_rdy = 1'b0;
   logic        hyp_busy = 1'b0;

   int tests = 0;
   int fails = 0;

   hyp_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst_l(rst_l),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .hyp_rd_req(hyp_rd_req), .hyp_wr_req(hyp_wr_req), .hyp_addr(hyp_addr),
      .hyp_wr_d(hyp_wr_d), .hyp_wr_byte_en(hyp_wr_byte_en),
      .hyp_rd_d(hyp_rd_d), .hyp_rd_rdy(hyp_rd_rdy), .hyp_busy(hyp_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset ----
      rst_l = 1'b1;
      #2 rst_l = 1'b0;
      #1;
      chk1("rst_m0_ready", m0_ready, 1'b0);
      chk1("rst_m1_ready", m1_ready, 1'b0);
      chk1("rst_rd_req", hyp_rd_req, 1'b0);
      chk1("rst_wr_req", hyp_wr_req, 1'b0);
      chk32("rst_hyp_addr", hyp_addr, 32'h0);
      step();
      step();
      rst_l = 1'b1;
      step();

      // ---- read on port 0: busy for several cycles, two strobes, the later one wins ----
      m0_valid = 1'b1; m0_addr = 30'h0000010; m0_wstrb = 4'h0;
      step();                                   // REQ
      chk1("rd_rd_req", hyp_rd_req, 1'b1);
      chk1("rd_wr_req", hyp_wr_req, 1'b0);
      chk32("rd_hyp_addr", hyp_addr, 32'h00000010);
      hyp_busy = 1'b1;
      step();                                   // GUARD
      chk1("rd_guard_req", hyp_rd_req, 1'b0);
      step();                                   // WAIT, cnt=1
      hyp_rd_rdy = 1'b1; hyp_rd_d = 32'h11111111;
      step();                                   // WAIT
      hyp_rd_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk1("rd_wait_ready", m0_ready, 1'b0);
         chk1("rd_wait_req", hyp_rd_req, 1'b0);
         step();
      end
      hyp_rd_rdy = 1'b1; hyp_rd_d = 32'hDEADBEEF;
      step();
      hyp_rd_rdy = 1'b0; hyp_busy = 1'b0;
      step();                                   // DONE
      chk1("rd_m0_ready", m0_ready, 1'b1);
      chk32("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk1("rd_m0_err", m0_err, 1'b0);
      chk1("rd_m1_ready", m1_ready, 1'b0);
      chk32("rd_m1_rdata", m1_rdata, 32'h0);
      chk32("rd_addr_stable", hyp_addr, 32'h00000010);
      m0_valid = 1'b0;
      step();                                   // IDLE
      chk1("rd_ready_pulse", m0_ready, 1'b0);
      chk32("rd_rdata_idle", m0_rdata, 32'h0);

      // ---- write on port 1 at the top address; a stray strobe must not reach rdata ----
      m1_valid = 1'b1; m1_addr = 30'h3FFFFFFF; m1_wdata = 32'h12345678; m1_wstrb = 4'h3;
      step();                                   // REQ
      chk1("wr_wr_req", hyp_wr_req, 1'b1);
      chk1("wr_rd_req", hyp_rd_req, 1'b0);
      chk32("wr_hyp_addr", hyp_addr, 32'h3FFFFFFF);
      chk32("wr_wr_d", hyp_wr_d, 32'h12345678);
      chk32("wr_byte_en", {28'h0, hyp_wr_byte_en}, 32'h3);
      hyp_busy = 1'b1;
      step();                                   // GUARD
      hyp_rd_rdy = 1'b1; hyp_rd_d = 32'hAAAA5555;
      step();                                   // WAIT
      hyp_rd_rdy = 1'b0; hyp_busy = 1'b0;
      step();                                   // DONE
      chk1("wr_m1_ready", m1_ready, 1'b1);
      chk32("wr_m1_rdata", m1_rdata, 32'h0);
      chk1("wr_m1_err", m1_err, 1'b0);
      chk1("wr_m0_ready", m0_ready, 1'b0);
      chk32("wr_addr_stable", hyp_addr, 32'h3FFFFFFF);
      m1_valid = 1'b0;
      step();                                   // IDLE

      // ---- reset during WAIT ----
      m0_valid = 1'b1; m0_addr = 30'h0000020; m0_wstrb = 4'h0;
      step();                                   // REQ
      hyp_busy = 1'b1;
      step();                                   // GUARD
      step();                                   // WAIT
      chk32("mid_addr", hyp_addr, 32'h00000020);
      rst_l = 1'b0;
      #1;
      chk32("mid_rst_addr", hyp_addr, 32'h0);
      chk1("mid_rst_ready", m0_ready, 1'b0);
      chk1("mid_rst_rd_req", hyp_rd_req, 1'b0);
      m0_valid = 1'b0; hyp_busy = 1'b0;
      step();
      rst_l = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk1("post_rst_ready", m0_ready, 1'b0);
         chk1("post_rst_rd_req", hyp_rd_req, 1'b0);
      end

      // ---- contention straight after reset: grants alternate, starting with port 0 ----
      m0_valid = 1'b1; m0_addr = 30'h0000100; m0_wstrb = 4'h0;
      m1_valid = 1'b1; m1_addr = 30'h0000200; m1_wstrb = 4'h0;
      for (int g = 0; g < 4; g++) begin
         step();                                // REQ
         chk1("ct_rd_req", hyp_rd_req, 1'b1);
         chk32("ct_addr", hyp_addr, (g % 2 == 0) ? 32'h00000100 : 32'h00000200);
         step();                                // GUARD
         chk1("ct_guard_req", hyp_rd_req, 1'b0);
         step();                                // WAIT
         chk1("ct_wait_req", hyp_rd_req, 1'b0);
         step();                                // DONE
         chk1("ct_m0_ready", m0_ready, g % 2 == 0);
         chk1("ct_m1_ready", m1_ready, g % 2 == 1);
         step();                                // IDLE
         chk1("ct_idle_req", hyp_rd_req, 1'b0);
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
      step();

      // ---- timeout: busy stuck high, ready arrives 10 cycles after the request ----
      m0_valid = 1'b1; m0_addr = 30'h0000040; m0_wstrb = 4'h0;
      step();                                   // REQ
      chk1("to_rd_req", hyp_rd_req, 1'b1);
      hyp_busy = 1'b1;
      for (int k = 1; k < 10; k++) begin
         step();
         chk1("to_early_ready", m0_ready, 1'b0);
      end
      step();                                   // DONE
      chk1("to_m0_ready", m0_ready, 1'b1);
      chk1("to_m0_err", m0_err, 1'b1);
      chk32("to_m0_rdata", m0_rdata, 32'h0);

      // ---- still busy at idle: no new grant until busy drops ----
      for (int i = 0; i < 4; i++) begin
         step();
         chk1("busy_idle_rd_req", hyp_rd_req, 1'b0);
         chk1("busy_idle_wr_req", hyp_wr_req, 1'b0);
      end
      hyp_busy = 1'b0;
      step();                                   // REQ
      chk1("busy_release_req", hyp_rd_req, 1'b1);
      step();                                   // GUARD
      step();                                   // WAIT
      step();                                   // DONE
      chk1("busy_release_ready", m0_ready, 1'b1);
      chk1("busy_release_err", m0_err, 1'b0);
      m0_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
